// File: rtl/sync_mod10.sv
// Synchronous mod-MODULUS (decade by default) counter with a terminal-count decode.
// Define SYNC_MOD10_SEG_EN to add a 7-segment output decoded from the count.
module sync_mod10 #(
    parameter int MODULUS = 10,
    parameter int WIDTH   = 4
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] q,
    output logic             tc
`ifdef SYNC_MOD10_SEG_EN
    ,
    output logic [6:0]       seg
`endif
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] q_nxt;

`ifdef SYNC_MOD10_SEG_EN
    // Active-high {g,f,e,d,c,b,a}; anything outside 0..9 is blanked.
    function automatic logic [6:0] seg_code(input logic [WIDTH-1:0] v);
        logic [6:0] code;
        case (int'(v))
            0:       code = 7'h3F;
            1:       code = 7'h06;
            2:       code = 7'h5B;
            3:       code = 7'h4F;
            4:       code = 7'h66;
            5:       code = 7'h6D;
            6:       code = 7'h7D;
            7:       code = 7'h07;
            8:       code = 7'h7F;
            9:       code = 7'h6F;
            default: code = 7'h00;
        endcase
        return code;
    endfunction
`endif

    // Terminal value and every illegal value both fold back to zero.
    always_comb begin
        q_nxt = q + WIDTH'(1);
        if (q >= LAST) begin
            q_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end

    assign tc = (q == LAST);

`ifdef SYNC_MOD10_SEG_EN
    assign seg = seg_code(q);
`endif

endmodule

// File: tb/tb_sync_mod10.sv
// Directed self-checking bench for sync_mod10: reset, counting, wrap, async reset,
// illegal-state recovery, tc pulse spacing, and the optional 7-segment decode.
`timescale 1ns/1ps
module tb_sync_mod10;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] q;
    logic       tc;
`ifdef SYNC_MOD10_SEG_EN
    logic [6:0] seg;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
`endif

    int total = 0;
    int bad   = 0;

    sync_mod10 #(.MODULUS(10), .WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (q),
        .tc    (tc)
`ifdef SYNC_MOD10_SEG_EN
        ,
        .seg   (seg)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_q;
        int pulses;
        int last_idx;
        int wide;
        logic prev_tc;

        reset = 1'b0;

        // Reset held for 100 ns: q and tc stay zero and never unknown.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_q", 32'(q), 32'd0);
            chk("rst_tc", 32'(tc), 32'd0);
            chk("rst_x", 32'($isunknown({q, tc})), 32'd0);
`ifdef SYNC_MOD10_SEG_EN
            chk("rst_seg", 32'(seg), 32'h3F);
`endif
        end

        // Release between edges, then 12 edges: 1..9,0,1,2.
        reset = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            exp_q = i % 10;
            chk("cnt_q", 32'(q), 32'(exp_q));
            chk("cnt_tc", 32'(tc), (exp_q == 9) ? 32'd1 : 32'd0);
`ifdef SYNC_MOD10_SEG_EN
            chk("cnt_seg", 32'(seg), 32'(seg_tab[exp_q]));
`endif
        end

        // Advance to 5, then assert reset between edges.
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_q", 32'(q), 32'd5);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_q", 32'(q), 32'd0);
        chk("async_rst_tc", 32'(tc), 32'd0);
        for (int i = 0; i < 3; i++) begin
            #10;
            chk("rst_hold_q", 32'(q), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_q", 32'(q), 32'd1);

        // Illegal value 12 recovers to 0, then counts on.
        @(negedge clk);
        force dut.q = 4'd12;
        #1;
        release dut.q;
        #1;
        chk("ill_q", 32'(q), 32'd12);
        chk("ill_tc", 32'(tc), 32'd0);
`ifdef SYNC_MOD10_SEG_EN
        chk("ill_seg12", 32'(seg), 32'h00);
`endif
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("ill_rec_q", 32'(q), 32'(i));
        end

`ifdef SYNC_MOD10_SEG_EN
        @(negedge clk);
        force dut.q = 4'd11;
        #1;
        release dut.q;
        #1;
        chk("ill_seg11", 32'(seg), 32'h00);
        chk("ill11_tc", 32'(tc), 32'd0);
        @(posedge clk);
        #1;
        chk("ill11_rec_q", 32'(q), 32'd0);
`endif

        // 100 edges: exactly 10 single-cycle tc pulses, 10 clocks apart.
        pulses   = 0;
        last_idx = -1;
        wide     = 0;
        prev_tc  = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (tc) begin
                if (prev_tc) begin
                    wide++;
                end else begin
                    pulses++;
                    if (last_idx >= 0) begin
                        chk("tc_space", 32'(i - last_idx), 32'd10);
                    end
                    last_idx = i;
                end
            end
            prev_tc = tc;
        end
        chk("tc_pulses", 32'(pulses), 32'd10);
        chk("tc_width", 32'(wide), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
